uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Oversampling UART receiver, 8N1 format. Recovers bytes from the serial `rx` pin for the downstream packet-protocol FSM, which consumes `uart_byte`/`data_rdy`.
- Runs entirely in the UART sampling clock domain; one clock is OVERSAMPLE × the baud rate.
- Emits exactly one `data_rdy` pulse per correctly framed byte and flags framing errors separately.

Parameters:
- OVERSAMPLE, 16, sampling-clock cycles per bit; even, ≥ 8.
- MID, OVERSAMPLE/2, counter value at bit centre (derived; not to be overridden).

Ports:
- uart_sampling_clk  input  1  sampling clock, OVERSAMPLE × baud.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  raw serial line, asynchronous to the clock; idles high.
- uart_byte  output  8  last correctly received byte; held until the next good byte.
- data_rdy  output  1  one-cycle pulse; `uart_byte` is valid in the same cycle.
- framing_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high while in any state other than IDLE.

Behaviour:
- Reset (`rst_n` low, async): state=IDLE, counters=0, shift register=0, `uart_byte`=8'h00, `data_rdy`=0, `framing_err`=0, `busy`=0. Synchronizer flops reset to 1 (line idle).
- Synchronizer: `rx` passes through 2 flops to give `rx_s`. `rx_d` is `rx_s` delayed one cycle. Edge detect: `rx_d`=1 && `rx_s`=0.
- Counters: `tick` runs 0..OVERSAMPLE-1 and wraps, then advances to the next bit. `bitcnt` runs 0..7.
- Bit decision: majority of `rx_s` at tick MID-1, MID, MID+1. Decision is made at the edge where tick=MID+1.
- Timing reference: E0 is the edge at which IDLE sees the falling edge; tick=0 after E0. Bit k (start=0, data 1..8, stop=9) is decided at edge E0 + k·OVERSAMPLE + MID+1.
- FSM:
  - IDLE: on falling edge → START, tick=0. Otherwise stay.
  - START: at the decision, majority=1 is a false start → IDLE, no outputs. At tick wrap → DATA, bitcnt=0.
  - DATA: at each decision, shift the majority bit in LSB-first (shift right, new bit enters bit 7). At tick wrap, bitcnt++; after bitcnt=7 wraps → STOP.
  - STOP, majority=1: register `uart_byte` ← shift register, pulse `data_rdy` in the following cycle, → IDLE immediately (this allows early detection of a back-to-back start bit).
  - STOP, majority=0: pulse `framing_err` next cycle, `uart_byte` unchanged, no `data_rdy`, → BREAK.
  - BREAK: wait until `rx_s`=1, then → IDLE. A line held low indefinitely produces only one `framing_err`.
- `data_rdy` and `framing_err` are never high in the same cycle. Each is high for exactly 1 cycle per byte.
- No receive FIFO: a new good byte overwrites `uart_byte`. The downstream stage must consume it in the `data_rdy` cycle.
- Glitch rejection: a low pulse shorter than MID-1 cycles is rejected as a false start.
- Reset asserted mid-frame aborts the frame. The remainder of that frame is ignored unless its bits happen to present a falling edge in IDLE; no partial byte is ever output.
- Latency, pin to `data_rdy`: falling edge on `rx` → E0 after 3 edges (2 sync + edge register). `data_rdy` is high during the cycle after edge E0+9·OVERSAMPLE+MID+1, which is E0+154 for OVERSAMPLE=16.
- Target size: approximately 150–250 lines of RTL.

Test Plan:
- Reset then send 8'hA5 8N1 at 16 cycles/bit → exactly one `data_rdy` pulse, `uart_byte`=8'hA5, `framing_err` never set, `busy` back to 0 after the stop decision.
- Back-to-back frames 8'hFF, 8'hF0, 8'h0F with zero idle gap → three `data_rdy` pulses, 160 cycles apart, bytes in order; `uart_byte` holds 8'h0F afterwards.
- Low glitch of 4 cycles on an idle line → no `data_rdy`, no `framing_err`, FSM returns to IDLE by tick MID+1. Then a valid 8'h3C is received correctly.
- Frame 8'h55 with stop bit forced low, then line held low for 100 cycles → one `framing_err` pulse, no `data_rdy`, `uart_byte` keeps its previous value. After the line returns high, 8'h12 is received correctly.
- Single-cycle inversion on the rx sample at tick MID of data bit 3 of 8'h00 → majority vote still yields 8'h00.
- Assert `rst_n` low at bit 5 of a frame → all outputs 0 immediately (asynchronously). After release and line idle, the next frame 8'hC3 yields `uart_byte`=8'hC3.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte and status out of the UART receiver
interface uart_rx_if;
  logic       rx;
  logic [7:0] uart_byte;
  logic       data_rdy;
  logic       framing_err;
  logic       busy;

  modport master (
    input  rx,
    output uart_byte,
    output data_rdy,
    output framing_err,
    output busy
  );

  modport slave (
    output rx,
    input  uart_byte,
    input  data_rdy,
    input  framing_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver with 3-sample majority vote per bit
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic      uart_sampling_clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_DEC  = TW'(MID);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state;
  logic [TW-1:0] tick;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic [7:0]    byte_r;
  logic          rdy_r;
  logic          ferr_r;
  logic          busy_r;

  logic sync1;
  logic rx_s;
  logic rx_d;
  logic rx_dd;
  logic fall;
  logic maj;
  logic decide;
  logic wrap;

  // Two-flop synchronizer plus two delay stages; rx_dd/rx_d/rx_s are three consecutive samples.
  always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
      rx_dd <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
      rx_dd <= rx_d;
    end
  end

  assign fall   = rx_d & ~rx_s;
  assign maj    = (rx_dd & rx_d) | (rx_dd & rx_s) | (rx_d & rx_s);
  assign decide = (tick == TICK_DEC);
  assign wrap   = (tick == TICK_LAST);

  always_ff @(posedge uart_sampling_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tick   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      byte_r <= '0;
      rdy_r  <= 1'b0;
      ferr_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      rdy_r  <= 1'b0;
      ferr_r <= 1'b0;
      case (state)
        IDLE: begin
          tick   <= '0;
          bitcnt <= '0;
          if (fall) begin
            state  <= START;
            busy_r <= 1'b1;
          end
        end
        START: begin
          tick <= wrap ? '0 : tick + 1'b1;
          if (decide && maj) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            tick   <= '0;
          end else if (wrap) begin
            state  <= DATA;
            bitcnt <= '0;
          end
        end
        DATA: begin
          tick <= wrap ? '0 : tick + 1'b1;
          if (decide) begin
            shreg <= {maj, shreg[7:1]};
          end
          if (wrap) begin
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          tick <= wrap ? '0 : tick + 1'b1;
          // Leaving at the stop-bit centre lets a back-to-back start edge be caught.
          if (decide) begin
            tick <= '0;
            if (maj) begin
              byte_r <= shreg;
              rdy_r  <= 1'b1;
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              ferr_r <= 1'b1;
              state  <= BRK;
            end
          end
        end
        BRK: begin
          tick <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          tick   <= '0;
        end
      endcase
    end
  end

  assign bus.uart_byte   = byte_r;
  assign bus.data_rdy    = rdy_r;
  assign bus.framing_err = ferr_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx
module tb_uart_rx;

  localparam int OS = 16;

  logic clk;
  logic rst_n;
  int   cyc;

  uart_rx_if u_if ();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .uart_sampling_clk(clk),
    .rst_n            (rst_n),
    .bus              (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int         tests;
  int         failed;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         ferr_cnt;
  int         both_cnt;
  int         rd;

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.data_rdy) begin
        got_q.push_back(u_if.uart_byte);
        got_t.push_back(cyc);
      end
      if (u_if.framing_err) ferr_cnt <= ferr_cnt + 1;
      if (u_if.data_rdy && u_if.framing_err) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input string tag);
    logic [7:0] e;
    logic [7:0] o;
    e = exp_q.pop_front();
    o = (rd < got_q.size()) ? got_q[rd] : 8'hxx;
    check(tag, 32'(o), 32'(e));
    rd++;
  endtask

  // One 8N1 frame. inv_k flips rx for one cycle at the centre of bit inv_k;
  // abort_k returns right after bit abort_k starts.
  task automatic send(input logic [7:0] b, input logic stop_bit, input int inv_k,
                      input int abort_k, output int t_start);
    logic [9:0] frame;
    frame   = {stop_bit, b, 1'b0};
    t_start = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 u_if.rx = frame[k];
      if (k == 0) t_start = cyc;
      if (k == abort_k) return;
      for (int j = 1; j < OS; j++) begin
        @(posedge clk);
        #1 u_if.rx = (k == inv_k && j == 8) ? ~frame[k] : frame[k];
      end
    end
  endtask

  int t0;
  int n;

  initial begin
    rst_n   = 1'b0;
    u_if.rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_byte", 32'(u_if.uart_byte), 32'h00);
    check("rst_rdy", 32'(u_if.data_rdy), 32'h0);
    check("rst_ferr", 32'(u_if.framing_err), 32'h0);
    check("rst_busy", 32'(u_if.busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, -1, -1, t0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    expect_byte("a5_byte");
    check("a5_latency", (got_t.size() > 0) ? 32'(got_t[0] - t0) : 32'hFFFF, 32'd156);
    check("a5_busy_after", 32'(u_if.busy), 32'h0);
    check("a5_rdy_count", 32'(got_q.size()), 32'd1);

    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h0F);
    send(8'hFF, 1'b1, -1, -1, t0);
    send(8'hF0, 1'b1, -1, -1, t0);
    send(8'h0F, 1'b1, -1, -1, t0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    expect_byte("b2b_ff");
    expect_byte("b2b_f0");
    expect_byte("b2b_0f");
    check("b2b_gap1", (got_t.size() > 2) ? 32'(got_t[2] - got_t[1]) : 32'hFFFF, 32'd160);
    check("b2b_gap2", (got_t.size() > 3) ? 32'(got_t[3] - got_t[2]) : 32'hFFFF, 32'd160);
    check("b2b_hold", 32'(u_if.uart_byte), 32'h0F);

    @(posedge clk);
    #1 u_if.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 u_if.rx = 1'b1;
    @(negedge clk);
    check("glitch_busy_on", 32'(u_if.busy), 32'h1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_off", 32'(u_if.busy), 32'h0);
    repeat (30) @(posedge clk);
    check("glitch_no_rdy", 32'(got_q.size()), 32'd4);
    check("glitch_no_ferr", 32'(ferr_cnt), 32'd0);

    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1, -1, -1, t0);
    repeat (20) @(posedge clk);
    expect_byte("after_glitch_3c");

    send(8'h55, 1'b0, -1, -1, t0);
    repeat (100) @(posedge clk);
    #1 u_if.rx = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("brk_ferr_once", 32'(ferr_cnt), 32'd1);
    check("brk_no_rdy", 32'(got_q.size()), 32'd5);
    check("brk_byte_kept", 32'(u_if.uart_byte), 32'h3C);
    check("brk_idle", 32'(u_if.busy), 32'h0);

    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, -1, -1, t0);
    repeat (20) @(posedge clk);
    expect_byte("after_brk_12");

    exp_q.push_back(8'h00);
    send(8'h00, 1'b1, 4, -1, t0);
    repeat (20) @(posedge clk);
    expect_byte("vote_00");

    send(8'h99, 1'b1, -1, 5, t0);
    @(negedge clk);
    check("abort_busy_before", 32'(u_if.busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_byte", 32'(u_if.uart_byte), 32'h00);
    check("abort_rdy", 32'(u_if.data_rdy), 32'h0);
    check("abort_ferr", 32'(u_if.framing_err), 32'h0);
    check("abort_busy", 32'(u_if.busy), 32'h0);
    u_if.rx = 1'b1;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    n = got_q.size();
    exp_q.push_back(8'hC3);
    send(8'hC3, 1'b1, -1, -1, t0);
    repeat (20) @(posedge clk);
    check("abort_one_rdy", 32'(got_q.size() - n), 32'd1);
    expect_byte("after_abort_c3");

    check("total_rdy", 32'(got_q.size()), 32'd8);
    check("total_ferr", 32'(ferr_cnt), 32'd1);
    check("never_both", 32'(both_cnt), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
